decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised RV32I/E instruction-decode stage between fetch and execute. It replaces the fixed ID stage with:
- valid/ready handshakes on both sides;
- an internal NUM_REGS register file;
- full immediate generation (I/S/B/U/J);
- a pending-write scoreboard that stalls issue on RAW/WAW hazards;
- a synchronous flush.

Outputs are registered: a one-entry pipeline register feeding EX.

## Interface
Parameters:
- DATA_WIDTH, 32, register/operand/PC width (≥32; immediates sign-extended to it)
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E); localparam ADDR_WIDTH = $clog2(NUM_REGS)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  decode accepts it this cycle (combinational)
- instr_i  in  32  instruction word
- pc_i  in  DATA_WIDTH  PC of instr_i
- wb_we_i  in  1  writeback write enable
- wb_waddr_i  in  5  writeback destination
- wb_wdata_i  in  DATA_WIDTH  writeback data
- flush_i  in  1  kill ID input and output register
- ex_valid_o  out  1  output register holds an instruction
- ex_ready_i  in  1  EX consumes it
- ex_pc_o  out  DATA_WIDTH  PC
- ex_rs1_data_o, ex_rs2_data_o  out  DATA_WIDTH  operand values (0 if unused)
- ex_imm_o  out  DATA_WIDTH  sign-extended immediate (0 for R-type)
- ex_rd_o  out  5  destination register
- ex_rd_we_o  out  1  instruction writes rd (never for rd = x0)
- ex_opcode_o  out  7, ex_funct3_o  out  3, ex_funct7_o  out  7  raw fields for EX decode
- ex_illegal_o  out  1  unknown opcode or register index ≥ NUM_REGS
- stall_o  out  1  if_valid_i high but blocked by hazard

## Operation
- **Register file:** NUM_REGS×DATA_WIDTH.
  - x0 reads 0; writes to x0 are ignored.
  - Written at the clock edge when wb_we_i is high.
- **Register usage by opcode:**
  - R 0110011: rs1, rs2, rd
  - I-ALU 0010011, LOAD 0000011, JALR 1100111: rs1, rd
  - STORE 0100011, BRANCH 1100011: rs1, rs2
  - LUI 0110111, AUIPC 0010111, JAL 1101111: rd only
  - Any other opcode: illegal. No reads, rd_we = 0, ex_illegal_o = 1, but the instruction still issues.
- **Scoreboard:** pending[NUM_REGS], x0 never set.
  - Set pending[ex_rd_o] on handoff (ex_valid_o & ex_ready_i & ~flush_i & ex_rd_we_o).
  - Clear pending[wb_waddr_i] on wb_we_i.
  - Same-register set and clear in the same cycle: set wins.
- **hazard** is high when either condition holds:
  - any used rs, or rd when rd_we, has its pending bit set;
  - ex_valid_o & ex_rd_we_o & ex_rd_o matches any used rs or rd.
  - Each register has at most one writer in flight.
- **Handshake:**
  - if_ready_o = ~flush_i & ~hazard & (~ex_valid_o | ex_ready_i).
  - Accept = if_valid_i & if_ready_o. On accept, the output register loads the decoded fields and ex_valid_o = 1.
  - Handoff without accept clears ex_valid_o.
  - stall_o = if_valid_i & hazard.
- **Flush:**
  - flush_i clears ex_valid_o next cycle.
  - Blocks accept and handoff that cycle, so a flushed occupant never sets pending.
  - Already-set pending bits are retained.
- **Output fields:** hold stable while ex_valid_o & ~ex_ready_i.

## Timing
- Reset: every output register is 0 (ex_valid_o, all ex_* fields), pending all 0. After reset, if_ready_o = 1.
- Latency: accept in cycle N → ex_valid_o in cycle N+1.
- Throughput: 1 instruction/cycle absent hazards.
- Back-pressure: ex_ready_i low with ex_valid_o high → if_ready_o low in the same cycle.
- RAW on an in-flight writer: issue resumes when the writeback clears the bit (see Configuration).
- Reset asserted mid-operation: output register and scoreboard clear immediately; register-file contents are undefined.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A pending bit being cleared by wb_we_i in the current cycle does not count as hazard.
  - rs data matching wb_waddr_i (nonzero) is taken from wb_wdata_i.
  - A dependent instruction issues in the writeback cycle.
- Undefined:
  - No bypass. The dependent instruction issues in the cycle after writeback and reads the register file.
  - This costs one extra stall cycle.

## Test plan
- **Reset and data path:** reset, then 5 independent ADDI x1..x5 back-to-back with ex_ready_i = 1 → ex_valid_o high 5 consecutive cycles from cycle 1; imm/rd match each instruction; stall_o never asserted.
- **Immediates:** issue SW x2,-4(x1), BEQ offset -8, LUI 0xABCDE, JAL +2048 → ex_imm_o = 0xFFFFFFFC, 0xFFFFFFF8, 0xABCDE000, 0x00000800.
- **RAW on occupant:** ADDI x3 then ADD x4,x3,x3; writeback of x3 = 7 arrives k cycles later → stall_o high until writeback. ADD's ex_rs1/rs2_data = 7. It issues in the writeback cycle with DECODE_WB_BYPASS_EN, one cycle later without.
- **Back-pressure:** hold ex_ready_i low 3 cycles with ex_valid_o high → if_ready_o low; ex_* outputs stable; no pending bit set; release → handoff in 1 cycle.
- **Flush:** flush_i in the same cycle as a would-be handoff of ADDI x6 → ex_valid_o = 0 next cycle; pending[6] stays 0; a following read of x6 issues without stall.
- **x0 and illegal:** ADDI x0,x0,5 followed by ADD x1,x0,x0 → no stall; ex_rd_we_o = 0. Opcode 1111111 → ex_illegal_o = 1, no scoreboard change. With NUM_REGS = 16, rs1 = x20 → ex_illegal_o = 1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/E decode: regfile read, immediate generation, pending-write scoreboard, one-entry output register.
// Latency: instruction accepted in cycle N is presented to EX in cycle N+1; one instruction per cycle.
// Backpressure: if_ready_o drops on hazard, flush or a stalled occupant; optional DECODE_WB_BYPASS_EN forwards writeback data.
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_valid_i,
    output logic                  if_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  wb_we_i,
    input  logic [4:0]            wb_waddr_i,
    input  logic [DATA_WIDTH-1:0] wb_wdata_i,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_pc_o,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic [4:0]            ex_rd_o,
    output logic                  ex_rd_we_o,
    output logic [6:0]            ex_opcode_o,
    output logic [2:0]            ex_funct3_o,
    output logic [6:0]            ex_funct7_o,
    output logic                  ex_illegal_o,
    output logic                  stall_o
);

    localparam int         ADDR_WIDTH = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS      = 6'(NUM_REGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   set_m, clr_m, pend_eff;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        use_rs1, use_rs2, use_rd, known;
    logic [31:0] imm32;
    logic        illegal, rs1_used, rs2_used, rd_we;
    logic        hazard, accept, handoff;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    // Register usage and immediate format by opcode
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        known   = 1'b1;
        imm32   = '0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm32  = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            default: known = 1'b0;
        endcase
    end

    // An illegal instruction touches no registers, so it can never create or wait on a hazard
    assign illegal  = ~known | (use_rs1 & ({1'b0, rs1} >= NREGS))
                             | (use_rs2 & ({1'b0, rs2} >= NREGS))
                             | (use_rd  & ({1'b0, rd}  >= NREGS));
    assign rs1_used = use_rs1 & ~illegal;
    assign rs2_used = use_rs2 & ~illegal;
    assign rd_we    = use_rd & ~illegal & (rd != 5'd0);

    assign handoff  = ex_valid_o & ex_ready_i & ~flush_i;

    // Scoreboard set/clear masks, hazard detection and operand read
    always_comb begin
        set_m = '0;
        clr_m = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            set_m[i] = handoff & ex_rd_we_o & (ex_rd_o == 5'(i));
            clr_m[i] = wb_we_i & (wb_waddr_i == 5'(i));
        end
`ifdef DECODE_WB_BYPASS_EN
        pend_eff = pending_q & ~clr_m;
`else
        pend_eff = pending_q;
`endif
        hazard = (rs1_used & pend_eff[rs1[ADDR_WIDTH-1:0]])
               | (rs2_used & pend_eff[rs2[ADDR_WIDTH-1:0]])
               | (rd_we    & pend_eff[rd[ADDR_WIDTH-1:0]])
               | (ex_valid_o & ex_rd_we_o & ((rs1_used & (ex_rd_o == rs1))
                                           | (rs2_used & (ex_rd_o == rs2))
                                           | (rd_we    & (ex_rd_o == rd))));
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_used && rs1 != 5'd0) begin
            rs1_data = regs[rs1[ADDR_WIDTH-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_we_i && wb_waddr_i == rs1) rs1_data = wb_wdata_i;
`endif
        end
        if (rs2_used && rs2 != 5'd0) begin
            rs2_data = regs[rs2[ADDR_WIDTH-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_we_i && wb_waddr_i == rs2) rs2_data = wb_wdata_i;
`endif
        end
    end

    assign if_ready_o = ~flush_i & ~hazard & (~ex_valid_o | ex_ready_i);
    assign accept     = if_valid_i & if_ready_o;
    assign stall_o    = if_valid_i & hazard;

    // Register file write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wb_we_i && wb_waddr_i != 5'd0 && {1'b0, wb_waddr_i} < NREGS)
            regs[wb_waddr_i[ADDR_WIDTH-1:0]] <= wb_wdata_i;
    end

    // Pending-write scoreboard; a same-cycle set overrides the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= (pending_q & ~clr_m) | set_m;
    end

    // Output register to EX: load on accept, drop on handoff or flush, otherwise hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rd_o       <= '0;
            ex_rd_we_o    <= 1'b0;
            ex_opcode_o   <= '0;
            ex_funct3_o   <= '0;
            ex_funct7_o   <= '0;
            ex_illegal_o  <= 1'b0;
        end else if (accept) begin
            ex_valid_o    <= 1'b1;
            ex_pc_o       <= pc_i;
            ex_rs1_data_o <= rs1_data;
            ex_rs2_data_o <= rs2_data;
            ex_imm_o      <= DATA_WIDTH'($signed(imm32));
            ex_rd_o       <= (use_rd & ~illegal) ? rd : 5'd0;
            ex_rd_we_o    <= rd_we;
            ex_opcode_o   <= opcode;
            ex_funct3_o   <= instr_i[14:12];
            ex_funct7_o   <= instr_i[31:25];
            ex_illegal_o  <= illegal;
        end else if (handoff || flush_i) begin
            ex_valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        if_valid_i = 1'b0, if_ready_o;
    logic [31:0] instr_i = '0, pc_i = '0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_waddr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        ex_valid_o, ex_ready_i = 1'b0;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rd_we_o, ex_illegal_o, stall_o;
    logic [6:0]  ex_opcode_o, ex_funct7_o;
    logic [2:0]  ex_funct3_o;

    logic        e_if_ready_o, e_ex_valid_o, e_ex_rd_we_o, e_ex_illegal_o, e_stall_o;
    logic [31:0] e_ex_pc_o, e_ex_rs1_data_o, e_ex_rs2_data_o, e_ex_imm_o;
    logic [4:0]  e_ex_rd_o;
    logic [6:0]  e_ex_opcode_o, e_ex_funct7_o;
    logic [2:0]  e_ex_funct3_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rd;
        logic        rd_we, ill;
        logic [6:0]  op;
    } exp_t;
    exp_t q[$];

    always #5 clk_i = ~clk_i;

    decode_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o), .ex_opcode_o(ex_opcode_o),
        .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o), .ex_illegal_o(ex_illegal_o),
        .stall_o(stall_o));

    decode_stage #(.DATA_WIDTH(32), .NUM_REGS(16)) u_dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni), .if_valid_i(if_valid_i), .if_ready_o(e_if_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i), .flush_i(flush_i), .ex_valid_o(e_ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(e_ex_pc_o), .ex_rs1_data_o(e_ex_rs1_data_o), .ex_rs2_data_o(e_ex_rs2_data_o),
        .ex_imm_o(e_ex_imm_o), .ex_rd_o(e_ex_rd_o), .ex_rd_we_o(e_ex_rd_we_o), .ex_opcode_o(e_ex_opcode_o),
        .ex_funct3_o(e_ex_funct3_o), .ex_funct7_o(e_ex_funct7_o), .ex_illegal_o(e_ex_illegal_o),
        .stall_o(e_stall_o));

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, 3'b000, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic [4:0] rd, input logic rd_we,
                                input logic ill, input logic [6:0] op);
        exp_t e;
        e.pc = pc; e.imm = imm; e.rs1d = rs1d; e.rs2d = rs2d;
        e.rd = rd; e.rd_we = rd_we; e.ill = ill; e.op = op;
        return e;
    endfunction

    // One clock: at the falling edge, compare any handoff against the scoreboard head
    task automatic cycle();
        exp_t e;
        @(negedge clk_i);
        if (ex_valid_o && ex_ready_i && !flush_i) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL handoff_unexpected pc=%h", ex_pc_o);
            end else begin
                e = q.pop_front();
                if ({ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, ex_illegal_o, ex_opcode_o}
                    !== {e.pc, e.imm, e.rs1d, e.rs2d, e.rd, e.rd_we, e.ill, e.op}) begin
                    bad++;
                    $display("FAIL handoff pc=%h imm=%h rs1=%h rs2=%h rd=%0d we=%b ill=%b op=%b want pc=%h imm=%h rs1=%h rs2=%h rd=%0d we=%b ill=%b op=%b",
                             ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, ex_illegal_o, ex_opcode_o,
                             e.pc, e.imm, e.rs1d, e.rs2d, e.rd, e.rd_we, e.ill, e.op);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction until accepted (bounded); reports the number of stall cycles
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, output int stalls);
        bit acc = 0;
        stalls = 0;
        q.push_back(e);
        if_valid_i = 1'b1; instr_i = instr; pc_i = pc;
        for (int c = 0; c < 20 && !acc; c++) begin
            #2;
            if (if_ready_o) acc = 1;
            else if (stall_o) stalls++;
            cycle();
        end
        if_valid_i = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL issue_timeout pc=%h never accepted", pc);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d;
        cycle();
        wb_we_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; if_valid_i = 1'b0; flush_i = 1'b0; wb_we_i = 1'b0; ex_ready_i = 1'b0;
        q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain_check(input string name);
        for (int c = 0; c < 4 && q.size() != 0; c++) cycle();
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL %s_drain left=%0d want=0", name, q.size()); end
    endtask

    task automatic test_reset();
        int s;
        do_reset();
        #2;
        total++;
        if ({ex_valid_o, if_ready_o, stall_o, ex_pc_o, ex_imm_o, ex_rd_we_o, ex_illegal_o, ex_rd_o} !== {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL reset_state valid=%b rdy=%b stall=%b pc=%h imm=%h we=%b want 0 1 0 0 0 0", ex_valid_o, if_ready_o, stall_o, ex_pc_o, ex_imm_o, ex_rd_we_o);
        end
        issue(enc_i(7'b0010011, 5'd1, 5'd0, 32'd1), 32'h40, mk(32'h40, 32'd1, 0, 0, 5'd1, 1'b1, 1'b0, 7'b0010011), s);
        rst_ni = 1'b0;
        #1;
        total++;
        if ({ex_valid_o, ex_pc_o} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL midop_reset valid=%b pc=%h want 0 0", ex_valid_o, ex_pc_o);
        end
        do_reset();
    endtask

    task automatic test_datapath();
        int s;
        int st_total = 0;
        do_reset();
        ex_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            issue(enc_i(7'b0010011, 5'(i), 5'd0, 32'(i * 3)), 32'h100 + 32'(4 * i),
                  mk(32'h100 + 32'(4 * i), 32'(i * 3), 0, 0, 5'(i), 1'b1, 1'b0, 7'b0010011), s);
            st_total += s;
            total++;
            if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL dp_valid_%0d got=%b want=1", i, ex_valid_o); end
        end
        total++;
        if (st_total !== 0) begin bad++; $display("FAIL dp_stalls got=%0d want=0", st_total); end
        drain_check("dp");
    endtask

    task automatic test_immediates();
        int s;
        do_reset();
        ex_ready_i = 1'b1;
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        issue(enc_s(5'd1, 5'd2, 32'hFFFFFFFC), 32'h200, mk(32'h200, 32'hFFFFFFFC, 32'h11, 32'h22, 5'd0, 1'b0, 1'b0, 7'b0100011), s);
        issue(enc_b(5'd1, 5'd2, 32'hFFFFFFF8), 32'h204, mk(32'h204, 32'hFFFFFFF8, 32'h11, 32'h22, 5'd0, 1'b0, 1'b0, 7'b1100011), s);
        issue({20'hABCDE, 5'd7, 7'b0110111}, 32'h208, mk(32'h208, 32'hABCDE000, 0, 0, 5'd7, 1'b1, 1'b0, 7'b0110111), s);
        issue(enc_j(5'd8, 32'h800), 32'h20C, mk(32'h20C, 32'h00000800, 0, 0, 5'd8, 1'b1, 1'b0, 7'b1101111), s);
        drain_check("imm");
    endtask

    task automatic test_raw();
        int s;
        int acc_c = -1;
        int want_c;
        logic want_st;
        do_reset();
        ex_ready_i = 1'b1;
        issue(enc_i(7'b0010011, 5'd3, 5'd0, 32'd1), 32'h300, mk(32'h300, 32'd1, 0, 0, 5'd3, 1'b1, 1'b0, 7'b0010011), s);
        q.push_back(mk(32'h304, 32'h0, 32'd7, 32'd7, 5'd4, 1'b1, 1'b0, 7'b0110011));
        if_valid_i = 1'b1; instr_i = enc_r(5'd4, 5'd3, 5'd3); pc_i = 32'h304;
`ifdef DECODE_WB_BYPASS_EN
        want_c = 3; want_st = 1'b0;
`else
        want_c = 4; want_st = 1'b1;
`endif
        for (int c = 0; c < 20 && acc_c < 0; c++) begin
            wb_we_i = (c == 3); wb_waddr_i = 5'd3; wb_wdata_i = 32'd7;
            #2;
            if (c <= 3) begin
                total++;
                if (stall_o !== ((c < 3) ? 1'b1 : want_st)) begin
                    bad++; $display("FAIL raw_stall_c%0d got=%b want=%b", c, stall_o, (c < 3) ? 1'b1 : want_st);
                end
            end
            if (if_ready_o) acc_c = c;
            cycle();
        end
        wb_we_i = 1'b0; if_valid_i = 1'b0;
        total++;
        if (acc_c !== want_c) begin bad++; $display("FAIL raw_issue_cycle got=%0d want=%0d", acc_c, want_c); end
        drain_check("raw");
    endtask

    task automatic test_backpressure();
        int s;
        do_reset();
        ex_ready_i = 1'b0;
        issue(enc_i(7'b0010011, 5'd5, 5'd0, 32'd9), 32'h400, mk(32'h400, 32'd9, 0, 0, 5'd5, 1'b1, 1'b0, 7'b0010011), s);
        q.push_back(mk(32'h404, 32'd10, 0, 0, 5'd6, 1'b1, 1'b0, 7'b0010011));
        if_valid_i = 1'b1; instr_i = enc_i(7'b0010011, 5'd6, 5'd0, 32'd10); pc_i = 32'h404;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if ({if_ready_o, ex_valid_o, ex_imm_o, ex_pc_o, ex_rd_o} !== {1'b0, 1'b1, 32'd9, 32'h400, 5'd5}) begin
                bad++;
                $display("FAIL bp_hold_c%0d rdy=%b valid=%b imm=%h pc=%h rd=%0d want 0 1 9 400 5", c, if_ready_o, ex_valid_o, ex_imm_o, ex_pc_o, ex_rd_o);
            end
            cycle();
        end
        ex_ready_i = 1'b1;
        #2;
        total++;
        if (if_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%b want=1", if_ready_o); end
        cycle();
        if_valid_i = 1'b0;
        total++;
        if ({ex_valid_o, ex_pc_o} !== {1'b1, 32'h404}) begin
            bad++; $display("FAIL bp_next valid=%b pc=%h want 1 404", ex_valid_o, ex_pc_o);
        end
        drain_check("bp");
    endtask

    task automatic test_flush();
        int s;
        exp_t dropped;
        do_reset();
        ex_ready_i = 1'b1;
        wb_write(5'd6, 32'h66);
        issue(enc_i(7'b0010011, 5'd6, 5'd0, 32'd3), 32'h500, mk(32'h500, 32'd3, 0, 0, 5'd6, 1'b1, 1'b0, 7'b0010011), s);
        dropped = q.pop_back();
        flush_i = 1'b1;
        #2;
        total++;
        if (if_ready_o !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%b want=0", if_ready_o); end
        cycle();
        flush_i = 1'b0;
        total++;
        if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0 (pc %h)", ex_valid_o, dropped.pc); end
        issue(enc_r(5'd7, 5'd6, 5'd6), 32'h504, mk(32'h504, 32'h0, 32'h66, 32'h66, 5'd7, 1'b1, 1'b0, 7'b0110011), s);
        total++;
        if (s !== 0) begin bad++; $display("FAIL flush_no_pending stalls=%0d want=0", s); end
        drain_check("flush");
    endtask

    task automatic test_x0_illegal();
        int s;
        do_reset();
        ex_ready_i = 1'b1;
        wb_write(5'd9, 32'h99);
        wb_write(5'd20, 32'h2020);
        issue(enc_i(7'b0010011, 5'd0, 5'd0, 32'd5), 32'h600, mk(32'h600, 32'd5, 0, 0, 5'd0, 1'b0, 1'b0, 7'b0010011), s);
        total++;
        if (ex_rd_we_o !== 1'b0) begin bad++; $display("FAIL x0_rd_we got=%b want=0", ex_rd_we_o); end
        issue(enc_r(5'd1, 5'd0, 5'd0), 32'h604, mk(32'h604, 32'h0, 0, 0, 5'd1, 1'b1, 1'b0, 7'b0110011), s);
        total++;
        if (s !== 0) begin bad++; $display("FAIL x0_stall stalls=%0d want=0", s); end
        issue({7'b0, 5'd9, 5'd9, 3'b000, 5'd9, 7'b1111111}, 32'h608, mk(32'h608, 32'h0, 0, 0, 5'd0, 1'b0, 1'b1, 7'b1111111), s);
        issue(enc_r(5'd10, 5'd9, 5'd9), 32'h60C, mk(32'h60C, 32'h0, 32'h99, 32'h99, 5'd10, 1'b1, 1'b0, 7'b0110011), s);
        total++;
        if (s !== 0) begin bad++; $display("FAIL illegal_no_sb stalls=%0d want=0", s); end
        issue(enc_i(7'b0010011, 5'd11, 5'd20, 32'd0), 32'h610, mk(32'h610, 32'h0, 32'h2020, 0, 5'd11, 1'b1, 1'b0, 7'b0010011), s);
        total++;
        if ({e_ex_valid_o, e_ex_illegal_o, e_ex_rd_we_o} !== {1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rv32e_illegal valid=%b ill=%b we=%b want 1 1 0", e_ex_valid_o, e_ex_illegal_o, e_ex_rd_we_o);
        end
        drain_check("x0ill");
    endtask

    initial begin
        test_reset();
        test_datapath();
        test_immediates();
        test_raw();
        test_backpressure();
        test_flush();
        test_x0_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
